// File: rtl/rc_pipe_pkg.sv
// rc_pipe_pkg: shared PIPE power-state codes, detect status code and controller state type.
package rc_pipe_pkg;
    localparam logic [1:0] PD_P0      = 2'b00;
    localparam logic [1:0] PD_P0S     = 2'b01;
    localparam logic [1:0] PD_P1      = 2'b10;
    localparam logic [1:0] PD_P2      = 2'b11;
    localparam logic [2:0] RXSTAT_DET = 3'b011;

    typedef enum logic [2:0] {
        ST_RST_WAIT,
        ST_IDLE,
        ST_PD_WAIT,
        ST_DET_WAIT,
        ST_DET_END
    } state_t;

    // Transmitter is forced to electrical idle in every state other than P0.
    function automatic logic pd_low_power(input logic [1:0] pd);
        return pd == PD_P0S || pd == PD_P1 || pd == PD_P2;
    endfunction
endpackage

// File: rtl/rc_pipe_mac_phyctl_if.sv
// rc_pipe_mac_phyctl_if: PIPE-side and LTSSM-side signals of the MAC PHY controller.
interface rc_pipe_mac_phyctl_if;
    logic       PhyStatus;
    logic [2:0] RxStatus_0;
    logic [1:0] PowerDown;
    logic       TxDetectRx_Loopback;
    logic       TxElecIdle_0;
    logic       tx_idle_req;
    logic       loopback_req;
    logic       pd_req;
    logic [1:0] pd_target;
    logic       det_req;
    logic       busy;
    logic       pd_done;
    logic       det_done;
    logic       det_present;
    logic       phy_ready;
    logic       err_timeout;
    logic       clr_err;

    modport master (
        input  PhyStatus, RxStatus_0, tx_idle_req, loopback_req, pd_req, pd_target, det_req, clr_err,
        output PowerDown, TxDetectRx_Loopback, TxElecIdle_0, busy, pd_done, det_done, det_present,
               phy_ready, err_timeout
    );
    modport slave (
        output PhyStatus, RxStatus_0, tx_idle_req, loopback_req, pd_req, pd_target, det_req, clr_err,
        input  PowerDown, TxDetectRx_Loopback, TxElecIdle_0, busy, pd_done, det_done, det_present,
               phy_ready, err_timeout
    );
endinterface

// File: rtl/rc_pipe_tmo_cnt.sv
// rc_pipe_tmo_cnt: saturating handshake timer; expire is high once the count reaches TMO_CYC-1.
module rc_pipe_tmo_cnt #(
    parameter int TMO_W   = 12,
    parameter int TMO_CYC = 4000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam logic [TMO_W-1:0] LAST = TMO_W'(TMO_CYC - 1);

    logic [TMO_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && r_cnt != LAST)
            r_cnt <= r_cnt + TMO_W'(1);
    end

    assign o_expire = r_cnt == LAST;
endmodule

// File: rtl/rc_pipe_mac_phyctl.sv
// rc_pipe_mac_phyctl: MAC-side PIPE controller serialising LTSSM power-state, receiver-detect
// and loopback requests into PhyStatus handshakes, with a timeout guard.
module rc_pipe_mac_phyctl
    import rc_pipe_pkg::*;
#(
    parameter int         TMO_W   = 12,
    parameter int         TMO_CYC = 4000,
    parameter logic [1:0] RST_PD  = 2'b10
) (
    input  logic                 PCLK,
    input  logic                 RESET,
    rc_pipe_mac_phyctl_if.master pipe
);
    state_t     r_state, w_state;
    logic [1:0] r_pd, w_pd;
    logic       r_txdet, w_txdet, r_eidle, w_eidle, r_busy, r_phy_ready, r_ps_low;
    logic       r_pd_done, w_pd_done, r_det_done, w_det_done;
    logic       r_det_present, w_det_present, r_err, w_err;
    logic       w_wait, w_expire, w_tmo;

    assign w_wait = r_state == ST_PD_WAIT || r_state == ST_DET_WAIT;
    assign w_tmo  = w_wait && w_expire && !pipe.PhyStatus;

    rc_pipe_tmo_cnt #(.TMO_W(TMO_W), .TMO_CYC(TMO_CYC)) u_tmo (
        .clk     (PCLK),
        .rst     (RESET),
        .i_clr   (r_state == ST_IDLE),
        .i_en    (w_wait),
        .o_expire(w_expire)
    );

    always_comb begin
        w_state       = r_state;
        w_pd          = r_pd;
        w_pd_done     = 1'b0;
        w_det_done    = 1'b0;
        w_det_present = r_det_present;
        case (r_state)
            ST_RST_WAIT: if (!pipe.PhyStatus && r_ps_low) w_state = ST_IDLE;
            ST_IDLE: begin
                if (pipe.det_req) begin
                    w_det_present = 1'b0;
                    if (r_pd == PD_P1) w_state = ST_DET_WAIT;
                    else w_det_done = 1'b1;
                end else if (pipe.pd_req) begin
                    if (pipe.pd_target == r_pd) begin
                        w_pd_done = 1'b1;
                    end else begin
                        w_pd    = pipe.pd_target;
                        w_state = ST_PD_WAIT;
                    end
                end
            end
            ST_PD_WAIT: begin
                if (pipe.PhyStatus || w_expire) begin
                    w_pd_done = 1'b1;
                    w_state   = ST_IDLE;
                end
            end
            ST_DET_WAIT: begin
                if (pipe.PhyStatus) begin
                    w_det_present = pipe.RxStatus_0 == RXSTAT_DET;
                    w_state       = ST_DET_END;
                end else if (w_expire) begin
                    w_det_done = 1'b1;
                    w_state    = ST_IDLE;
                end
            end
            ST_DET_END: begin
                w_det_done = 1'b1;
                w_state    = ST_IDLE;
            end
            default: w_state = ST_RST_WAIT;
        endcase
        if (w_tmo) w_det_present = 1'b0;
        // Loopback is only honoured when idle in P0; otherwise the pin is the detect strobe.
        w_txdet = w_tmo ? 1'b0
                : (w_state == ST_IDLE && w_pd == PD_P0) ? pipe.loopback_req
                : w_state == ST_DET_WAIT;
        w_eidle = (w_state == ST_IDLE || w_state == ST_PD_WAIT) && !pd_low_power(w_pd)
                ? pipe.tx_idle_req : 1'b1;
        w_err   = w_tmo || (r_err && !pipe.clr_err);
    end

    always_ff @(posedge PCLK or posedge RESET) begin
        if (RESET) begin
            r_state       <= ST_RST_WAIT;
            r_pd          <= RST_PD;
            r_txdet       <= 1'b0;
            r_eidle       <= 1'b1;
            r_busy        <= 1'b1;
            r_pd_done     <= 1'b0;
            r_det_done    <= 1'b0;
            r_det_present <= 1'b0;
            r_phy_ready   <= 1'b0;
            r_err         <= 1'b0;
            r_ps_low      <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_pd          <= w_pd;
            r_txdet       <= w_txdet;
            r_eidle       <= w_eidle;
            r_busy        <= w_state != ST_IDLE;
            r_pd_done     <= w_pd_done;
            r_det_done    <= w_det_done;
            r_det_present <= w_det_present;
            r_phy_ready   <= w_state != ST_RST_WAIT;
            r_err         <= w_err;
            r_ps_low      <= !pipe.PhyStatus;
        end
    end

    assign pipe.PowerDown           = r_pd;
    assign pipe.TxDetectRx_Loopback = r_txdet;
    assign pipe.TxElecIdle_0        = r_eidle;
    assign pipe.busy                = r_busy;
    assign pipe.pd_done             = r_pd_done;
    assign pipe.det_done            = r_det_done;
    assign pipe.det_present         = r_det_present;
    assign pipe.phy_ready           = r_phy_ready;
    assign pipe.err_timeout         = r_err;
endmodule

// File: tb/tb_rc_pipe_mac_phyctl.sv
// tb_rc_pipe_mac_phyctl: scenario tasks drive the controller; a scoreboard of expected
// done pulses (cycle + output snapshot) is popped by a monitor when pd_done/det_done fire.
module tb_rc_pipe_mac_phyctl;
    logic PCLK = 1'b0;
    logic RESET = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    typedef struct {
        int         cyc;
        logic [5:0] val;
    } exp_t;
    exp_t sb[$];

    rc_pipe_mac_phyctl_if bus();

    rc_pipe_mac_phyctl #(.TMO_W(12), .TMO_CYC(16), .RST_PD(2'b10)) dut (
        .PCLK (PCLK),
        .RESET(RESET),
        .pipe (bus)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc++;

    // {PowerDown, TxDetectRx_Loopback, TxElecIdle_0, busy, pd_done, det_done, det_present, phy_ready, err_timeout}
    wire [9:0] outs = {bus.PowerDown, bus.TxDetectRx_Loopback, bus.TxElecIdle_0, bus.busy,
                       bus.pd_done, bus.det_done, bus.det_present, bus.phy_ready, bus.err_timeout};
    localparam logic [9:0] RST_OUTS = 10'b10_0_1_1_0_0_0_0_0;

    always @(negedge PCLK) begin
        if (!RESET && (bus.pd_done || bus.det_done)) begin
            exp_t       e;
            logic [5:0] obs;
            obs = {bus.pd_done, bus.det_done, bus.PowerDown, bus.det_present, bus.err_timeout};
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL done_unexpected: pulse %b at cycle %0d, required no pulse", obs, cyc);
            end else begin
                e = sb.pop_front();
                if (obs !== e.val || cyc != e.cyc) begin
                    miscompares++;
                    $display("FAIL done_pulse: got %b at cycle %0d, required %b at cycle %0d",
                             obs, cyc, e.val, e.cyc);
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic test_reset();
        {bus.RxStatus_0, bus.tx_idle_req, bus.loopback_req, bus.pd_req} = '0;
        {bus.pd_target, bus.det_req, bus.clr_err} = '0;
        bus.PhyStatus = 1'b1;
        #1 RESET = 1'b1;
        step();
        vectors++;
        if (outs !== RST_OUTS) begin
            miscompares++;
            $display("FAIL reset_values: outs=%b required %b", outs, RST_OUTS);
        end
        step(2);
        RESET = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            vectors++;
            if (outs !== RST_OUTS) begin
                miscompares++;
                $display("FAIL rst_wait_hold: outs=%b required %b", outs, RST_OUTS);
            end
        end
        bus.PhyStatus = 1'b0;
        step();
        vectors++;
        if (bus.phy_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL phy_ready_early: phy_ready=%b required 0", bus.phy_ready);
        end
        step();
        vectors++;
        if (outs !== 10'b10_0_1_0_0_0_0_1_0) begin
            miscompares++;
            $display("FAIL phy_ready_rise: outs=%b required 1001000010", outs);
        end
    endtask

    task automatic test_pd_change();
        bus.pd_target = 2'b00;
        bus.pd_req = 1'b1;
        step();
        bus.pd_req = 1'b0;
        vectors++;
        if ({bus.PowerDown, bus.busy} !== 3'b00_1) begin
            miscompares++;
            $display("FAIL pd_drive: PowerDown,busy=%b required 001", {bus.PowerDown, bus.busy});
        end
        step(4);
        bus.PhyStatus = 1'b1;
        sb.push_back('{cyc + 1, 6'b10_00_0_0});
        step();
        bus.PhyStatus = 1'b0;
        vectors++;
        if ({bus.busy, bus.TxElecIdle_0} !== 2'b00) begin
            miscompares++;
            $display("FAIL pd_complete: busy,eidle=%b required 00", {bus.busy, bus.TxElecIdle_0});
        end
        step();
    endtask

    task automatic test_elec_idle();
        bus.tx_idle_req = 1'b1;
        step();
        vectors++;
        if (bus.TxElecIdle_0 !== 1'b1) begin
            miscompares++;
            $display("FAIL eidle_follow_hi: TxElecIdle_0=%b required 1", bus.TxElecIdle_0);
        end
        bus.tx_idle_req = 1'b0;
        step();
        vectors++;
        if (bus.TxElecIdle_0 !== 1'b0) begin
            miscompares++;
            $display("FAIL eidle_follow_lo: TxElecIdle_0=%b required 0", bus.TxElecIdle_0);
        end
    endtask

    task automatic test_det_not_p1();
        bus.det_req = 1'b1;
        sb.push_back('{cyc + 1, 6'b01_00_0_0});
        step();
        bus.det_req = 1'b0;
        vectors++;
        if ({bus.busy, bus.TxDetectRx_Loopback} !== 2'b00) begin
            miscompares++;
            $display("FAIL det_p0: busy,strobe=%b required 00", {bus.busy, bus.TxDetectRx_Loopback});
        end
        step();
    endtask

    task automatic test_loopback();
        bus.loopback_req = 1'b1;
        step();
        vectors++;
        if (bus.TxDetectRx_Loopback !== 1'b1) begin
            miscompares++;
            $display("FAIL loopback_on: TxDetectRx_Loopback=%b required 1", bus.TxDetectRx_Loopback);
        end
        bus.pd_target = 2'b10;
        bus.pd_req = 1'b1;
        step();
        bus.pd_req = 1'b0;
        vectors++;
        if (outs[9:6] !== 4'b10_0_1) begin
            miscompares++;
            $display("FAIL loopback_drop: PowerDown,strobe,eidle=%b required 1001", outs[9:6]);
        end
        bus.PhyStatus = 1'b1;
        sb.push_back('{cyc + 1, 6'b10_10_0_0});
        step();
        bus.PhyStatus = 1'b0;
        step();
        vectors++;
        if (bus.TxDetectRx_Loopback !== 1'b0) begin
            miscompares++;
            $display("FAIL loopback_p1: TxDetectRx_Loopback=%b required 0", bus.TxDetectRx_Loopback);
        end
        bus.loopback_req = 1'b0;
    endtask

    task automatic test_detect(input logic [2:0] rx, input logic present);
        bus.det_req = 1'b1;
        step();
        bus.det_req = 1'b0;
        vectors++;
        if ({bus.TxDetectRx_Loopback, bus.busy, bus.det_present} !== 3'b110) begin
            miscompares++;
            $display("FAIL det_start: strobe,busy,present=%b required 110",
                     {bus.TxDetectRx_Loopback, bus.busy, bus.det_present});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (bus.TxDetectRx_Loopback !== 1'b1) begin
                miscompares++;
                $display("FAIL det_strobe_hold: strobe=%b required 1", bus.TxDetectRx_Loopback);
            end
        end
        bus.PhyStatus = 1'b1;
        bus.RxStatus_0 = rx;
        sb.push_back('{cyc + 2, {4'b01_10, present, 1'b0}});
        step();
        bus.PhyStatus = 1'b0;
        bus.RxStatus_0 = 3'b000;
        vectors++;
        if ({bus.TxDetectRx_Loopback, bus.det_present} !== {1'b0, present}) begin
            miscompares++;
            $display("FAIL det_result: strobe,present=%b required %b",
                     {bus.TxDetectRx_Loopback, bus.det_present}, {1'b0, present});
        end
        step(2);
    endtask

    task automatic test_back_to_back();
        bus.det_req = 1'b1;
        bus.pd_req = 1'b1;
        bus.pd_target = 2'b00;
        step();
        {bus.det_req, bus.pd_req} = 2'b00;
        vectors++;
        if ({bus.PowerDown, bus.TxDetectRx_Loopback} !== 3'b10_1) begin
            miscompares++;
            $display("FAIL det_priority: PowerDown,strobe=%b required 101",
                     {bus.PowerDown, bus.TxDetectRx_Loopback});
        end
        bus.pd_req = 1'b1;
        step();
        bus.pd_req = 1'b0;
        bus.PhyStatus = 1'b1;
        bus.RxStatus_0 = 3'b011;
        sb.push_back('{cyc + 2, 6'b01_10_1_0});
        step();
        bus.PhyStatus = 1'b0;
        bus.RxStatus_0 = 3'b000;
        step(3);
        vectors++;
        if ({bus.PowerDown, bus.busy} !== 3'b10_0) begin
            miscompares++;
            $display("FAIL busy_drop: PowerDown,busy=%b required 100", {bus.PowerDown, bus.busy});
        end
    endtask

    task automatic test_timeout();
        bus.pd_target = 2'b11;
        bus.pd_req = 1'b1;
        sb.push_back('{cyc + 17, 6'b10_11_0_1});
        step();
        bus.pd_req = 1'b0;
        step(15);
        vectors++;
        if (bus.err_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_early: err_timeout=%b required 0", bus.err_timeout);
        end
        step();
        vectors++;
        if ({bus.err_timeout, bus.PowerDown, bus.busy} !== 4'b1_11_0) begin
            miscompares++;
            $display("FAIL tmo_set: err,PowerDown,busy=%b required 1110",
                     {bus.err_timeout, bus.PowerDown, bus.busy});
        end
        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
        vectors++;
        if (bus.err_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_clear: err_timeout=%b required 0", bus.err_timeout);
        end
        bus.pd_target = 2'b10;
        bus.pd_req = 1'b1;
        sb.push_back('{cyc + 17, 6'b10_10_0_1});
        step();
        bus.pd_req = 1'b0;
        step(15);
        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
        vectors++;
        if (bus.err_timeout !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_set_over_clr: err_timeout=%b required 1", bus.err_timeout);
        end
    endtask

    task automatic test_reset_mid_detect();
        bus.det_req = 1'b1;
        step();
        bus.det_req = 1'b0;
        vectors++;
        if ({bus.TxDetectRx_Loopback, bus.busy, bus.phy_ready, bus.err_timeout} !== 4'b1111) begin
            miscompares++;
            $display("FAIL det_wait_entry: strobe,busy,ready,err=%b required 1111",
                     {bus.TxDetectRx_Loopback, bus.busy, bus.phy_ready, bus.err_timeout});
        end
        #2 RESET = 1'b1;
        #1;
        vectors++;
        if (outs !== RST_OUTS) begin
            miscompares++;
            $display("FAIL async_reset: outs=%b required %b", outs, RST_OUTS);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_pd_change();
        test_elec_idle();
        test_det_not_p1();
        test_loopback();
        test_detect(3'b011, 1'b1);
        test_detect(3'b000, 1'b0);
        test_back_to_back();
        test_timeout();
        test_reset_mid_detect();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d done pulses missing, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
